// File: rtl/nw_score_engine_if.sv
// Job/result handshake bundle for nw_score_engine: the host drives the job and
// out_ready, and the engine drives in_ready, busy, out_valid and the score.
interface nw_score_engine_if #(
  parameter int MAXLEN = 16,
  parameter int CWIDTH = 2,
  parameter int SWIDTH = 16,
  parameter int LWIDTH = $clog2(MAXLEN + 1)
) ();
  logic                       in_valid;
  logic                       in_ready;
  logic [MAXLEN*CWIDTH-1:0]   s1;
  logic [MAXLEN*CWIDTH-1:0]   s2;
  logic [LWIDTH-1:0]          len1;
  logic [LWIDTH-1:0]          len2;
  logic                       mode;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [SWIDTH-1:0]   score;

  modport master (
    output in_valid, s1, s2, len1, len2, mode, out_ready,
    input  in_ready, busy, out_valid, score
  );

  modport slave (
    input  in_valid, s1, s2, len1, len2, mode, out_ready,
    output in_ready, busy, out_valid, score
  );
endinterface

// File: rtl/nw_score_engine.sv
// Sequential Needleman-Wunsch / Smith-Waterman scorer: a single scoring cell
// sweeps the DP matrix row by row, keeping only one row of H in registers.
module nw_score_engine #(
  parameter int        MAXLEN   = 16,
  parameter int        CWIDTH   = 2,
  parameter int        SWIDTH   = 16,
  parameter int        LWIDTH   = $clog2(MAXLEN + 1),
  parameter int signed MATCH    = 1,
  parameter int signed MISMATCH = -1,
  parameter int signed INDEL    = -1
) (
  input  logic              clk,
  input  logic              reset,
  nw_score_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROW, CELL, DONE} state_t;

  state_t state, stateNext;

  logic [MAXLEN*CWIDTH-1:0] s1r, s2r;
  logic [LWIDTH-1:0]        len1r, len2r, i, j;
  logic                     modeR, outValid;
  logic signed [SWIDTH-1:0] H [0:MAXLEN];
  logic signed [SWIDTH-1:0] diag, best, scoreReg;

  logic                     accept, zeroJob, lastCol, lastRow;
  logic [LWIDTH-1:0]        len1c, len2c;
  logic [CWIDTH-1:0]        charA, charB;
  logic signed [SWIDTH-1:0] sub, hDiag, hUp, hLeft, h, bestNext;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == ROW) || (state == CELL);
  assign bus.out_valid = outValid;
  assign bus.score     = scoreReg;

  assign accept  = bus.in_valid && (state == IDLE);
  assign len1c   = (bus.len1 > LWIDTH'(MAXLEN)) ? LWIDTH'(MAXLEN) : bus.len1;
  assign len2c   = (bus.len2 > LWIDTH'(MAXLEN)) ? LWIDTH'(MAXLEN) : bus.len2;
  assign zeroJob = (len1c == '0) || (len2c == '0);
  assign lastCol = (j >= len2r);
  assign lastRow = (i >= len1r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = zeroJob ? DONE : ROW;
      ROW:     stateNext = CELL;
      CELL:    if (lastCol) stateNext = lastRow ? DONE : ROW;
      DONE:    if (outValid && bus.out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One DP cell: diag is H[i-1][j-1], H[j] still holds row i-1, H[j-1] already holds row i.
  always_comb begin
    charA    = s1r[CWIDTH*(int'(i) - 1) +: CWIDTH];
    charB    = s2r[CWIDTH*(int'(j) - 1) +: CWIDTH];
    sub      = (charA == charB) ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
    hDiag    = diag + sub;
    hUp      = H[j] + SWIDTH'(INDEL);
    hLeft    = H[j - 1'b1] + SWIDTH'(INDEL);
    h        = hDiag;
    if (hUp > h)            h = hUp;
    if (hLeft > h)          h = hLeft;
    if (modeR && (h < 0))   h = '0;
    bestNext = (h > best) ? h : best;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1r      <= '0;
      s2r      <= '0;
      len1r    <= '0;
      len2r    <= '0;
      modeR    <= 1'b0;
      i        <= '0;
      j        <= '0;
      diag     <= '0;
      best     <= '0;
      scoreReg <= '0;
      outValid <= 1'b0;
      for (int k = 0; k <= MAXLEN; k++) H[k] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            s1r   <= bus.s1;
            s2r   <= bus.s2;
            len1r <= len1c;
            len2r <= len2c;
            modeR <= bus.mode;
            i     <= LWIDTH'(1);
            best  <= '0;
            for (int k = 0; k <= MAXLEN; k++)
              H[k] <= bus.mode ? '0 : SWIDTH'(k * INDEL);
            if (zeroJob)
              scoreReg <= bus.mode ? '0 : SWIDTH'((int'(len1c) + int'(len2c)) * INDEL);
          end
        end
        ROW: begin
          diag <= H[0];
          H[0] <= modeR ? '0 : SWIDTH'(int'(i) * INDEL);
          j    <= LWIDTH'(1);
        end
        CELL: begin
          diag <= H[j];
          H[j] <= h;
          if (modeR) best <= bestNext;
          if (!lastCol) begin
            j <= j + 1'b1;
          end else if (!lastRow) begin
            i <= i + 1'b1;
          end else begin
            scoreReg <= modeR ? bestNext : h;
            outValid <= 1'b1;
          end
        end
        DONE: begin
          // A zero-length job reaches DONE on the accept edge; out_valid follows one edge later.
          if (!outValid)              outValid <= 1'b1;
          else if (bus.out_ready)     outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_score_engine.sv
// Directed and randomized checks of nw_score_engine against a full-matrix
// alignment model, including latency, busy, backpressure and mid-job reset.
module tb_nw_score_engine;

  localparam int MAXLEN = 16;
  localparam int CWIDTH = 2;
  localparam int SWIDTH = 16;
  localparam int LWIDTH = $clog2(MAXLEN + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nw_score_engine_if #(.MAXLEN(MAXLEN), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .LWIDTH(LWIDTH)) bus ();

  nw_score_engine #(.MAXLEN(MAXLEN), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .LWIDTH(LWIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] packStr(input string s);
    logic [31:0] r = '0;
    for (int k = 0; k < s.len(); k++) begin
      case (s[k])
        "C":     r[k*2 +: 2] = 2'd1;
        "G":     r[k*2 +: 2] = 2'd2;
        "T":     r[k*2 +: 2] = 2'd3;
        default: r[k*2 +: 2] = 2'd0;
      endcase
    end
    return r;
  endfunction

  function automatic int clipLen(input int l);
    return (l > MAXLEN) ? MAXLEN : l;
  endfunction

  // Reference: full (len1+1)x(len2+1) DP matrix with match +1, mismatch -1, gap -1.
  function automatic int modelScore(input logic [31:0] a, input logic [31:0] b,
                                    input int l1, input int l2, input bit local_mode);
    int m [0:MAXLEN][0:MAXLEN];
    int best = 0;
    int n1 = clipLen(l1);
    int n2 = clipLen(l2);
    if (n1 == 0 || n2 == 0) return local_mode ? 0 : -(n1 + n2);
    for (int r = 0; r <= n1; r++) m[r][0] = local_mode ? 0 : -r;
    for (int c = 0; c <= n2; c++) m[0][c] = local_mode ? 0 : -c;
    for (int r = 1; r <= n1; r++) begin
      for (int c = 1; c <= n2; c++) begin
        int v;
        v = m[r-1][c-1] + ((a[(r-1)*2 +: 2] == b[(c-1)*2 +: 2]) ? 1 : -1);
        if (m[r-1][c] - 1 > v) v = m[r-1][c] - 1;
        if (m[r][c-1] - 1 > v) v = m[r][c-1] - 1;
        if (local_mode && v < 0) v = 0;
        m[r][c] = v;
        if (v > best) best = v;
      end
    end
    return local_mode ? best : m[n1][n2];
  endfunction

  function automatic int modelLatency(input int l1, input int l2);
    int n1 = clipLen(l1);
    int n2 = clipLen(l2);
    return (n1 == 0 || n2 == 0) ? 1 : n1 * (n2 + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a job and returns #1 after the edge on which it was accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int l1, input int l2, input bit m);
    int waitCnt = 0;
    bus.s1 = a;
    bus.s2 = b;
    bus.len1 = LWIDTH'(l1);
    bus.len2 = LWIDTH'(l2);
    bus.mode = m;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 200) checkOutput("accept_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int expScore, input int expLat,
                            input int expBusy);
    int edges = 0;
    int busyCnt = 0;
    while (!bus.out_valid && edges < 500) begin
      if (bus.busy) busyCnt++;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_latency"}, edges, expLat);
    checkOutput({tag, "_busy"}, busyCnt, expBusy);
    checkOutput({tag, "_score"}, $signed(bus.score), expScore);
  endtask

  task automatic finishJob(input string tag, input int delay, input int expScore);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_held"}, $signed(bus.score), expScore);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_ovdrop"}, bus.out_valid, 0);
    checkOutput({tag, "_ready"}, bus.in_ready, 1);
  endtask

  task automatic runJob(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int l1, input int l2, input bit m, input int expScore,
                        input int delay);
    int lat = modelLatency(l1, l2);
    int zero = (clipLen(l1) == 0 || clipLen(l2) == 0);
    applyStimulus(a, b, l1, l2, m);
    waitResult(tag, expScore, lat, zero ? 0 : lat);
    finishJob(tag, delay, expScore);
  endtask

  initial begin
    logic [31:0] acgt, gattaca, gcatgct;
    int ovSeen;
    acgt    = packStr("ACGT");
    gattaca = packStr("GATTACA");
    gcatgct = packStr("GCATGCT");
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.s1 = '0;
    bus.s2 = '0;
    bus.len1 = '0;
    bus.len2 = '0;
    bus.mode = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_score", $signed(bus.score), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    runJob("acgt_global", acgt, acgt, 4, 4, 1'b0, 4, 0);
    runJob("gattaca_global", gattaca, gcatgct, 7, 7, 1'b0, 0, 2);
    runJob("ttacgtt_local", packStr("TTACGTT"), packStr("GGACGGG"), 7, 7, 1'b1, 3, 1);
    runJob("zero_global", acgt, packStr("ACGTA"), 0, 5, 1'b0, -5, 0);
    runJob("zero_local", acgt, packStr("ACGTA"), 0, 5, 1'b1, 0, 0);

    // Backpressure with a second job offered the whole time.
    applyStimulus(acgt, acgt, 4, 4, 1'b0);
    waitResult("bp1", 4, 20, 20);
    bus.s1 = gattaca;
    bus.s2 = gcatgct;
    bus.len1 = LWIDTH'(7);
    bus.len2 = LWIDTH'(7);
    bus.mode = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_score_stable", $signed(bus.score), 4);
      checkOutput("bp_in_ready_low", bus.in_ready, 0);
      checkOutput("bp_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("bp_ovdrop", bus.out_valid, 0);
    checkOutput("bp_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitResult("bp2", 0, 56, 56);
    finishJob("bp2", 0, 0);

    // Reset in the middle of a job.
    applyStimulus(acgt, acgt, 4, 4, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ovSeen = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) ovSeen++;
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_valid", ovSeen, 0);
    runJob("after_rst", acgt, acgt, 4, 4, 1'b0, 4, 0);

    // Randomized jobs, including lengths beyond MAXLEN and junk past the used length.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      int l1, l2;
      bit m;
      a  = $urandom;
      b  = $urandom;
      l1 = (n % 6 == 5) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 16));
      l2 = (n % 7 == 3) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 16));
      m  = 1'($urandom_range(0, 1));
      runJob($sformatf("rand%0d", n), a, b, l1, l2, m, modelScore(a, b, l1, l2, m),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nw_score_engine.md
# nw_score_engine

Sequential Needleman-Wunsch / Smith-Waterman scoring engine: accepts one pair of character strings of run-time length up to MAXLEN and returns a single alignment score. Global or local mode is selected per job. It replaces the fully unrolled cell grid with one scoring cell plus a single-row score buffer, so area is O(MAXLEN) instead of O(MAXLEN²). Jobs are accepted and results returned over valid/ready handshakes, so a host sequencer or FIFO can drive it directly.

## Interface
- MAXLEN, 16, maximum characters per string
- CWIDTH, 2, bits per character
- SWIDTH, 16, bits per signed score
- LWIDTH, $clog2(MAXLEN+1), bits per length field
- MATCH, 1, signed substitution score when characters are equal
- MISMATCH, -1, signed substitution score when characters differ
- INDEL, -1, signed gap score
- clk  in  1  clock; single clock domain, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears FSM and outputs
- in_valid  in  1  job offered
- in_ready  out  1  engine idle and able to accept a job
- s1  in  MAXLEN*CWIDTH  string 1; char k at [k*CWIDTH +: CWIDTH]
- s2  in  MAXLEN*CWIDTH  string 2; same packing
- len1  in  LWIDTH  used length of s1
- len2  in  LWIDTH  used length of s2
- mode  in  1  0 = global (NW), 1 = local (SW)
- busy  out  1  job in progress (state ROW or CELL)
- out_valid  out  1  score valid
- out_ready  in  1  consumer takes score
- score  out  SWIDTH  signed result

## Operation
- States: IDLE, ROW, CELL, DONE. in_ready = (state==IDLE).
- Accept on the edge where in_valid && in_ready. The engine latches s1, s2, mode, and min(len, MAXLEN) for each length. It also sets i=1 and best=0, and initialises the row buffer H[0..MAXLEN] to j*INDEL (global) or 0 (local).
- If either latched length is 0: IDLE→DONE. score = (len1+len2)*INDEL in global mode, 0 in local mode.
- Otherwise IDLE→ROW.
- ROW (1 cycle):
  - diag ← H[0].
  - H[0] ← i*INDEL (global) or 0 (local).
  - j ← 1; go to CELL.
- CELL (1 cycle per j):
  - a = s1 char i-1, b = s2 char j-1.
  - sub = MATCH if a==b, else MISMATCH.
  - h = max(diag+sub, H[j]+INDEL, H[j-1]+INDEL). In local mode h = max(h, 0).
  - diag ← old H[j]; H[j] ← h.
  - Local mode: best ← max(best, h).
  - If j<len2: j++.
  - Else if i<len1: i++, go to ROW.
  - Else go to DONE with score = best (local) or h (global).
- DONE:
  - out_valid=1 and score held constant until out_valid && out_ready.
  - On that edge: out_valid←0, go to IDLE.
- Arithmetic: signed SWIDTH two's complement, no saturation; the integrator sizes SWIDTH. Tie order among max terms is irrelevant because only the score is output.
- Characters beyond len1/len2 are ignored.
- in_valid while not IDLE is ignored; no queueing.

## Timing
- Reset values: out_valid=0, score=0, busy=0, state=IDLE, so in_ready=1 while reset is high and after it.
- Reset asserted mid-job: the job is aborted immediately. No out_valid is produced, and buffer contents are don't-care.
- Latency, nonzero lengths: out_valid rises len1*(len2+1) edges after the accept edge.
- Latency, a zero length: out_valid rises 1 edge after the accept edge.
- Minimum job-to-job spacing: latency + 1 handshake edge. in_ready returns high the cycle after the output handshake.
- Output handshake can complete in the first cycle of out_valid if out_ready is already high.
- busy is high exactly during ROW/CELL cycles.

## Test plan
Parameters for all scenarios: defaults, with A=0, C=1, G=2, T=3.
- Global, s1=ACGT, s2=ACGT (len 4/4) -> score=4; out_valid exactly 20 edges after accept.
- Global, s1=GATTACA, s2=GCATGCT (len 7/7) -> score=0 at 56 edges after accept.
- Local, s1=TTACGTT, s2=GGACGGG (len 7/7) -> score=3.
- len1=0, len2=5:
  - Global -> score=-5 one edge after accept.
  - Local -> score=0.
  - busy never high.
- Backpressure:
  - Setup: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and a second job presented throughout.
  - Required: score stable and in_ready=0 for all 10 cycles; second job not accepted.
  - After out_ready=1: handshake completes, in_ready=1 on the next cycle, and the second job is then accepted and scores correctly.
- Assert reset for 1 cycle midway through job 1 -> out_valid stays 0, in_ready=1 immediately. A following job (ACGT/ACGT) returns 4 with the nominal latency.
